// File: rtl/lockin_demodulator.sv
// Lock-in demodulator: accumulates ADC samples over the on/off phases of a switching PWM and
// emits the averaged (on - off) difference per frame. Define LOCKIN_ROUND_EN for round-half-up.
module lockin_demodulator #(
  parameter int DATA_W       = 12,
  parameter int SAMPLES_LOG2 = 2,
  parameter int PERIODS_LOG2 = 1,
  parameter int SETTLE       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              switch_pwm,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              demod_valid,
  output logic [DATA_W:0]   demod_out,
  output logic              short_err,
  output logic              busy
);

  localparam int SHIFT = SAMPLES_LOG2 + PERIODS_LOG2;
  localparam int ACC_W = DATA_W + SHIFT;
  localparam int CNT_W = SAMPLES_LOG2 + 1;
  localparam int PC_W  = (PERIODS_LOG2 > 0) ? PERIODS_LOG2 : 1;

  localparam logic [CNT_W-1:0] N_SAMPLES   = CNT_W'(2 ** SAMPLES_LOG2);
  localparam logic [PC_W-1:0]  LAST_PERIOD = PC_W'(2 ** PERIODS_LOG2 - 1);
  localparam logic [3:0]       SETTLE_C    = 4'(SETTLE);
`ifdef LOCKIN_ROUND_EN
  localparam logic signed [ACC_W:0] ROUND_C = (ACC_W + 1)'(2 ** (SHIFT - 1));
`endif

  typedef enum logic [1:0] {IDLE, SYNC, ACCUM} state_t;

  state_t state_q, state_d;

  logic sw_meta, sw_s, sw_q;
  logic rise, fall, sw_edge;

  logic [3:0]       blank_cnt, blank_base;
  logic [CNT_W-1:0] samp_cnt, cnt_base;
  logic [PC_W-1:0]  period_cnt;
  logic [ACC_W-1:0] on_sum, off_sum, on_base, off_base;
  logic             frame_bad;
  logic             enable_q;

  logic take_blank, take_sample, phase_short, frame_end, frame_good;
  logic signed [ACC_W:0] diff, diff_adj;
  logic [DATA_W:0]       demod_next;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = SYNC;
      SYNC:    if (!enable) state_d = IDLE;
               else if (rise) state_d = ACCUM;
      ACCUM:   if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign busy = (state_q == SYNC) || (state_q == ACCUM);

  // An edge restarts the phase counters before the same-cycle sample is judged.
  always_comb begin
    rise        = sw_s & ~sw_q;
    fall        = ~sw_s & sw_q;
    sw_edge     = rise | fall;
    blank_base  = sw_edge ? '0 : blank_cnt;
    cnt_base    = sw_edge ? '0 : samp_cnt;
    take_blank  = sample_valid && (blank_base < SETTLE_C);
    take_sample = sample_valid && !take_blank && (cnt_base < N_SAMPLES);
    phase_short = samp_cnt < N_SAMPLES;
    frame_end   = rise && (period_cnt == LAST_PERIOD);
    frame_good  = !frame_bad && !phase_short;
    on_base     = frame_end ? '0 : on_sum;
    off_base    = frame_end ? '0 : off_sum;
    diff        = $signed({1'b0, on_sum}) - $signed({1'b0, off_sum});
`ifdef LOCKIN_ROUND_EN
    diff_adj    = diff + ROUND_C;
`else
    diff_adj    = diff;
`endif
    demod_next  = (DATA_W + 1)'(diff_adj >>> SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta     <= 1'b0;
      sw_s        <= 1'b0;
      sw_q        <= 1'b0;
      enable_q    <= 1'b0;
      blank_cnt   <= '0;
      samp_cnt    <= '0;
      period_cnt  <= '0;
      on_sum      <= '0;
      off_sum     <= '0;
      frame_bad   <= 1'b0;
      demod_valid <= 1'b0;
      demod_out   <= '0;
      short_err   <= 1'b0;
    end else begin
      sw_meta     <= switch_pwm;
      sw_s        <= sw_meta;
      sw_q        <= sw_s;
      enable_q    <= enable;
      demod_valid <= 1'b0;
      if (enable && !enable_q) short_err <= 1'b0;

      if (state_q == ACCUM && enable) begin
        blank_cnt <= take_blank ? blank_base + 4'd1 : blank_base;
        samp_cnt  <= take_sample ? cnt_base + CNT_W'(1) : cnt_base;
        on_sum    <= (take_sample && sw_s)  ? on_base + ACC_W'(sample_data)  : on_base;
        off_sum   <= (take_sample && !sw_s) ? off_base + ACC_W'(sample_data) : off_base;
        if (sw_edge && phase_short) short_err <= 1'b1;
        if (rise) period_cnt <= frame_end ? '0 : period_cnt + PC_W'(1);
        if (frame_end) begin
          frame_bad <= 1'b0;
          if (frame_good) begin
            demod_out   <= demod_next;
            demod_valid <= 1'b1;
          end
        end else if (sw_edge && phase_short) begin
          frame_bad <= 1'b1;
        end
      end else if (state_q == SYNC && enable && rise) begin
        // First on phase starts here; its edge-coincident sample is the first post-edge sample.
        blank_cnt  <= take_blank ? 4'd1 : 4'd0;
        samp_cnt   <= take_sample ? CNT_W'(1) : '0;
        on_sum     <= take_sample ? ACC_W'(sample_data) : '0;
        off_sum    <= '0;
        period_cnt <= '0;
        frame_bad  <= 1'b0;
      end else begin
        blank_cnt  <= '0;
        samp_cnt   <= '0;
        period_cnt <= '0;
        on_sum     <= '0;
        off_sum    <= '0;
        frame_bad  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lockin_demodulator.sv
// Self-checking bench for lockin_demodulator: directed frame table plus randomized frames
// checked against a phase-level reference model.
module tb_lockin_demodulator;

  localparam int DATA_W       = 12;
  localparam int SAMPLES_LOG2 = 2;
  localparam int PERIODS_LOG2 = 1;
  localparam int SETTLE       = 1;
  localparam int N_SAMP       = 1 << SAMPLES_LOG2;
  localparam int PERIODS      = 1 << PERIODS_LOG2;
  localparam int DIV          = 1 << (SAMPLES_LOG2 + PERIODS_LOG2);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              enable = 1'b0;
  logic              switch_pwm = 1'b0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] sample_data = '0;
  logic              demod_valid;
  logic [DATA_W:0]   demod_out;
  logic              short_err;
  logic              busy;

  lockin_demodulator #(
    .DATA_W(DATA_W), .SAMPLES_LOG2(SAMPLES_LOG2), .PERIODS_LOG2(PERIODS_LOG2), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .switch_pwm(switch_pwm),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .demod_valid(demod_valid), .demod_out(demod_out), .short_err(short_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] on_first, on_data, on_last, off_data;
    int                n_on, n_off, n_off_last;
    bit                exp_valid;
    logic [DATA_W:0]   exp_out;
    bit                exp_short;
  } frame_vec_t;

  frame_vec_t vecs[6];

  int n_checks = 0;
  int n_pass   = 0;
  int pulses_seen = 0;
  int pulses_exp  = 0;
  int edge_no     = 0;

  logic [DATA_W-1:0] phase_q[$];

  // Reference model state, tracked per phase and per frame.
  bit              m_enabled = 0;
  bit              m_in_frame = 0;
  int              m_period = 0;
  longint          m_on = 0, m_off = 0;
  bit              m_bad = 0;
  bit              m_short = 0;
  logic [DATA_W:0] m_last = '0;
  bit              cur_ok = 1;

  bit              tbl_pending = 0;
  int              tbl_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (demod_valid === 1'b1) pulses_seen++;
  endtask

  function automatic longint avg_of(input longint diff);
    longint d;
    d = diff;
`ifdef LOCKIN_ROUND_EN
    d = d + DIV / 2;
`endif
    if (d >= 0) return d / DIV;
    return -((-d + DIV - 1) / DIV);
  endfunction

  task automatic model_edge(input bit level, output bit pulse);
    pulse = 0;
    if (!m_enabled) return;
    if (!m_in_frame) begin
      if (level) begin
        m_in_frame = 1; m_period = 0; m_on = 0; m_off = 0; m_bad = 0;
      end
      return;
    end
    if (!cur_ok) begin
      m_bad = 1;
      m_short = 1;
    end
    if (level) begin
      m_period++;
      if (m_period == PERIODS) begin
        if (!m_bad) begin
          pulse = 1;
          m_last = 13'(avg_of(m_on - m_off));
          pulses_exp++;
        end
        m_period = 0; m_on = 0; m_off = 0; m_bad = 0;
      end
    end
  endtask

  // First SETTLE samples of a phase are blanked, the next N_SAMP count, the rest are ignored.
  task automatic phase_eval(input bit level);
    longint s;
    int     acc;
    s = 0;
    acc = 0;
    for (int k = SETTLE; k < phase_q.size() && acc < N_SAMP; k++) begin
      s += phase_q[k];
      acc++;
    end
    cur_ok = (acc == N_SAMP);
    if (m_enabled && m_in_frame) begin
      if (level) m_on += s;
      else       m_off += s;
    end
  endtask

  task automatic edge_checks(input bit level);
    bit pulse;
    model_edge(level, pulse);
    phase_eval(level);
    check($sformatf("edge%0d_valid", edge_no), demod_valid, pulse);
    check($sformatf("edge%0d_out", edge_no), demod_out, m_last);
    check($sformatf("edge%0d_short", edge_no), short_err, m_short);
    if (level && tbl_pending) begin
      check($sformatf("tbl%0d_valid", tbl_idx), demod_valid, vecs[tbl_idx].exp_valid);
      check($sformatf("tbl%0d_out", tbl_idx), demod_out, vecs[tbl_idx].exp_out);
      check($sformatf("tbl%0d_short", tbl_idx), short_err, vecs[tbl_idx].exp_short);
      tbl_pending = 0;
    end
    edge_no++;
  endtask

  // The switch edge reaches the demodulator two clocks after switch_pwm toggles; the first
  // sample of phase_q is driven in exactly that edge cycle.
  task automatic run_phase(input bit level, input int gap_max);
    sample_valid = 1'b0;
    switch_pwm = level;
    tick();
    tick();
    if (phase_q.size() == 0) begin
      tick();
      edge_checks(level);
    end else begin
      for (int k = 0; k < phase_q.size(); k++) begin
        sample_valid = 1'b1;
        sample_data = phase_q[k];
        tick();
        sample_valid = 1'b0;
        if (k == 0) edge_checks(level);
        repeat ($urandom_range(0, gap_max)) tick();
      end
    end
  endtask

  task automatic load_phase(input int n, input logic [DATA_W-1:0] first, mid, last);
    phase_q.delete();
    for (int k = 0; k < n; k++)
      phase_q.push_back((k == 0) ? first : ((k == n - 1) ? last : mid));
  endtask

  task automatic run_frame(input int i);
    load_phase(vecs[i].n_on, vecs[i].on_first, vecs[i].on_data, vecs[i].on_last);
    run_phase(1'b1, 1);
    load_phase(vecs[i].n_off, vecs[i].off_data, vecs[i].off_data, vecs[i].off_data);
    run_phase(1'b0, 1);
    load_phase(vecs[i].n_on, vecs[i].on_first, vecs[i].on_data, vecs[i].on_last);
    run_phase(1'b1, 1);
    load_phase(vecs[i].n_off_last, vecs[i].off_data, vecs[i].off_data, vecs[i].off_data);
    run_phase(1'b0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{12'h800, 12'h800, 12'h800, 12'h200, 5, 5, 5, 1'b1, 13'd1536, 1'b0};
    vecs[1] = '{12'h100, 12'h100, 12'h100, 12'h300, 5, 5, 5, 1'b1, 13'h1E00, 1'b0};
    vecs[2] = '{12'h800, 12'h800, 12'h800, 12'h200, 5, 5, 4, 1'b0, 13'h1E00, 1'b1};
    vecs[3] = '{12'h400, 12'h400, 12'h400, 12'h100, 5, 5, 5, 1'b1, 13'h300, 1'b1};
    vecs[4] = '{12'hFFF, 12'h400, 12'h400, 12'h200, 5, 5, 5, 1'b1, 13'h200, 1'b1};
`ifdef LOCKIN_ROUND_EN
    vecs[5] = '{12'h400, 12'h400, 12'h402, 12'h400, 5, 5, 5, 1'b1, 13'd1, 1'b1};
`else
    vecs[5] = '{12'h400, 12'h400, 12'h402, 12'h400, 5, 5, 5, 1'b1, 13'd0, 1'b1};
`endif

    #2 rst_n = 1'b0;
    #1;
    check("reset_valid", demod_valid, 1'b0);
    check("reset_out", demod_out, 13'd0);
    check("reset_short", short_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 1'b0);
    enable = 1'b1;
    m_enabled = 1;
    tick();
    tick();
    check("sync_busy", busy, 1'b1);

    for (int i = 0; i < 6; i++) begin
      run_frame(i);
      tbl_pending = 1;
      tbl_idx = i;
    end
    load_phase(3, 12'h800, 12'h800, 12'h800);
    run_phase(1'b1, 1);

    // Asynchronous reset in the middle of a frame.
    rst_n = 1'b0;
    #1;
    check("midrst_valid", demod_valid, 1'b0);
    check("midrst_out", demod_out, 13'd0);
    check("midrst_short", short_err, 1'b0);
    check("midrst_busy", busy, 1'b0);
    m_last = '0; m_short = 0; m_in_frame = 0;
    switch_pwm = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Full frame after reset, then drop enable part way through the next frame.
    run_frame(0);
    load_phase(5, 12'h800, 12'h800, 12'h800);
    run_phase(1'b1, 1);
    load_phase(5, 12'h200, 12'h200, 12'h200);
    run_phase(1'b0, 1);
    load_phase(5, 12'h800, 12'h800, 12'h800);
    run_phase(1'b1, 1);
    enable = 1'b0;
    m_enabled = 0;
    m_in_frame = 0;
    tick();
    tick();
    check("disable_busy", busy, 1'b0);
    load_phase(5, 12'h200, 12'h200, 12'h200);
    run_phase(1'b0, 1);
    load_phase(5, 12'h800, 12'h800, 12'h800);
    run_phase(1'b1, 1);
    check("disable_hold_out", demod_out, 13'd1536);
    phase_q.delete();
    run_phase(1'b0, 0);
    enable = 1'b1;
    m_enabled = 1;
    repeat (2) tick();

    // Randomized frames; frame 2 carries a forced short off phase.
    for (int f = 0; f < 12; f++) begin
      for (int p = 0; p < 2 * PERIODS; p++) begin
        int len;
        if (f == 2 && p == 1) len = 4;
        else if ($urandom_range(0, 7) == 0) len = $urandom_range(0, 4);
        else len = $urandom_range(5, 8);
        phase_q.delete();
        for (int k = 0; k < len; k++) phase_q.push_back(12'($urandom_range(0, 4095)));
        run_phase(p[0] == 1'b0, 2);
      end
    end
    phase_q.delete();
    for (int k = 0; k < 5; k++) phase_q.push_back(12'($urandom_range(0, 4095)));
    run_phase(1'b1, 2);

    // short_err is sticky through enable low and clears on the enable rising edge.
    enable = 1'b0;
    m_enabled = 0;
    m_in_frame = 0;
    tick();
    tick();
    check("short_sticky", short_err, 1'b1);
    enable = 1'b1;
    m_enabled = 1;
    tick();
    m_short = 0;
    check("short_clear", short_err, 1'b0);
    check("pulse_count", pulses_seen, pulses_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lockin_demodulator.md
Name: lockin_demodulator

Overview:
- Parametrised synchronous demodulator between the XADC sample stream and downstream processing.
- Accumulates ADC samples separately during the on and off phases of the switching PWM.
- Blanks settling samples after each switch edge and averages over 2^PERIODS_LOG2 switching periods.
- Emits the signed average difference (on - off) with a one-cycle valid strobe; all status is on ports.

Parameters:
- DATA_W, 12: ADC sample width (unsigned).
- SAMPLES_LOG2, 2: accepted samples per phase = 2^SAMPLES_LOG2.
- PERIODS_LOG2, 1: switching periods per result frame = 2^PERIODS_LOG2.
- SETTLE, 1: valid samples discarded after each switch edge (0..15).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: run demodulation; low forces IDLE.
- switch_pwm, input, 1: switching PWM (asynchronous); 1 = on phase.
- sample_valid, input, 1: one-cycle strobe marking a new sample.
- sample_data, input, DATA_W: unsigned ADC sample.
- demod_valid, output, 1: one-cycle pulse when a new result is available.
- demod_out, output, DATA_W+1: signed average of on minus off.
- short_err, output, 1: sticky flag; a phase ended with fewer than 2^SAMPLES_LOG2 accepted samples.
- busy, output, 1: high while in the SYNC or ACCUM state.

Behaviour:
- Reset (async, rst_n=0): state goes to IDLE; all accumulators, counters and synchroniser flops clear; demod_valid=0, demod_out=0, short_err=0, busy=0.
- Synchroniser: switch_pwm passes through 2 flops to give sw_s; sw_q is sw_s delayed one more cycle.
  - rise = sw_s & ~sw_q; fall = ~sw_s & sw_q.
  - The phase of any sample is the sw_s value in that same cycle.
- State IDLE: busy=0, accumulators held at 0. Goes to SYNC when enable=1.
- State SYNC: waits for rise, then goes to ACCUM with all counters cleared.
  - A sample that coincides with that rise is treated as the first post-edge sample of the on phase.
- State ACCUM:
  - On every rise or fall, the blanking counter and the phase sample counter reset to 0.
  - A sample_valid is blanked while blank_cnt < SETTLE; blank_cnt increments per blanked sample.
  - After blanking, samples are added to on_sum or off_sum until the phase count reaches 2^SAMPLES_LOG2. Further samples in that phase are ignored.
  - Accumulator width is DATA_W+SAMPLES_LOG2+PERIODS_LOG2, unsigned; overflow cannot occur.
  - At each edge, the count of the phase just ended is checked. If it is below 2^SAMPLES_LOG2, short_err is set and the frame is marked bad.
  - A period ends at a rise; the period counter increments there.
  - When the period counter wraps (2^PERIODS_LOG2 periods done) at a rise:
    - good frame: diff = on_sum - off_sum, signed, width +1; demod_out = diff >>> (SAMPLES_LOG2+PERIODS_LOG2), registered; demod_valid pulses on the next cycle. Latency is 1 clk after the rise cycle.
    - bad frame: no pulse and demod_out holds.
    - In either case, sums and the bad flag clear, and the new frame starts in the same cycle.
  - A sample coinciding with the frame-ending rise belongs to the new frame: it goes to the new on phase and is blanked if SETTLE>0.
- enable low in any state: IDLE next cycle; partial frame discarded; demod_out holds last value; short_err holds.
- short_err clears only on reset or on an enable rising edge.
- Edge and sample_valid in the same cycle: the edge resets the counters first, then the sample is evaluated against the reset counters.

Optional Feature:
- Macro: LOCKIN_ROUND_EN.
- Defined: before the shift, add 2^(SAMPLES_LOG2+PERIODS_LOG2-1) to diff, i.e. round half toward +inf.
- Undefined: plain arithmetic shift, i.e. floor (truncation toward -inf).

Test Plan (all with DATA_W=12, SAMPLES_LOG2=2, PERIODS_LOG2=1, SETTLE=1):
- Basic: 2 periods, each phase 5 valid samples, on=0x800, off=0x200 -> one demod_valid pulse 1 clk after the third rise, demod_out=+1536, short_err=0.
- Negative: on=0x100, off=0x300, same timing -> demod_out=-512 (13'h1E00).
- Short phase: second off phase has only 4 samples (1 blanked, 3 accepted) -> short_err=1, no demod_valid for that frame; the next good frame gives a pulse and the correct value.
- Edge-coincident sample: sample_valid=1 with value 0xFFF in the rise cycle of every on phase, others 0x400 -> the 0xFFF samples are blanked; demod_out=(0x400-off)/1 as normal.
- Rounding: on sums total 8*0x400+4, off total 8*0x400 -> with macro demod_out=1; without macro demod_out=0.
- Reset/enable mid-frame: assert rst_n=0 after 3 on samples -> all outputs 0 immediately; release, run a full frame -> correct result. Deassert enable mid-frame -> no pulse, demod_out holds previous value.
